// File: rtl/mealy_pkg.sv
// Shared state definitions for the 4-state Mealy line code, used by both
// the encoder and the receive-side decoder.
package mealy_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } mealy_state_t;

endpackage

// File: rtl/mealy_bit_decoder.sv
// Tracks the encoder's 4-state machine and recovers each original data bit
// from the encoded op. The state advances only on step; resync wins over step.
module mealy_bit_decoder
  import mealy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       resync,
  input  logic       code,
  output logic       data_bit,
  output logic [1:0] state
);

  mealy_state_t cur, nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S0;
    end else begin
      cur <= nxt;
    end
  end

  // data_bit is the decode of the current code regardless of step.
  always_comb begin
    data_bit = 1'b0;
    nxt      = cur;
    case (cur)
      S0: begin
        data_bit = code;
        if (step) nxt = code ? S1 : S0;
      end
      S1: begin
        data_bit = code;
        if (step) nxt = code ? S1 : S2;
      end
      S2: begin
        data_bit = ~code;
        if (step) nxt = ~code ? S2 : S3;
      end
      S3: begin
        data_bit = code;
        if (step) nxt = code ? S0 : S3;
      end
      default: begin
        data_bit = 1'b0;
        nxt      = S0;
      end
    endcase
    if (resync) nxt = S0;
  end

  assign state = cur;

endmodule

// File: rtl/mealy_decoder.sv
// Mealy line-code receiver: decodes the op stream and packs bits LSB first into
// WIDTH-bit words. Define MEALY_DEC_FLUSH_EN to add a flush port for partial words.
module mealy_decoder
  import mealy_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic             resync,
`ifdef MEALY_DEC_FLUSH_EN
  input  logic             flush,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: a bit moves when in_valid && in_ready; a word moves when
  // out_valid && out_ready. in_ready drops only while a word is stalled.
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] word_next;
  logic             accept;
  logic             dec_bit;
  logic             flush_fire;
  logic             emit;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !resync;

  mealy_bit_decoder u_tracker (
    .clk      (clk),
    .reset    (reset),
    .step     (accept),
    .resync   (resync),
    .code     (in_bit),
    .data_bit (dec_bit),
    .state    (dbg_state)
  );

`ifdef MEALY_DEC_FLUSH_EN
  assign flush_fire = flush && in_ready && !resync && (accept || cnt != '0);
`else
  assign flush_fire = 1'b0;
`endif

  always_comb begin
    word_next = shift;
    if (accept) word_next[cnt] = dec_bit;
  end

  assign emit = !resync && ((accept && cnt == LAST) || flush_fire);

  // shift is cleared after each word so a flushed word is zero above its last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      shift     <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (resync) begin
        cnt   <= '0;
        shift <= '0;
      end else if (emit) begin
        out_word  <= word_next;
        out_valid <= 1'b1;
        cnt       <= '0;
        shift     <= '0;
      end else if (accept) begin
        shift <= word_next;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mealy_decoder.sv
// Bench for mealy_decoder: directed scenarios followed by random traffic,
// compared every cycle against a table-driven line-code model.
module tb_mealy_decoder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             resync;
`ifdef MEALY_DEC_FLUSH_EN
  logic             flush;
`endif
  logic             out_valid;
  logic [WIDTH-1:0] out_word;
  logic             out_ready;
  logic [1:0]       dbg_state;

  mealy_decoder #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .resync    (resync),
`ifdef MEALY_DEC_FLUSH_EN
    .flush     (flush),
`endif
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: decode rule as lookup tables indexed by encoder state
  int m_inv  [4] = '{0, 0, 1, 0};
  int m_nxt1 [4] = '{1, 1, 2, 0};
  int m_nxt0 [4] = '{0, 2, 3, 3};
  int               m_state;
  int               m_cnt;
  logic [WIDTH-1:0] m_bits;
  logic [WIDTH-1:0] m_word;
  logic             m_valid;
  logic [WIDTH-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_bits  = '0;
    m_word  = '0;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  // Called at a negedge with inputs set: compare outputs, advance model, move one cycle.
  task automatic tick();
    logic ready, take, d, emit;
    #1;
    check("in_ready", in_ready, !m_valid || out_ready);
    check("out_valid", out_valid, m_valid);
    check("out_word", out_word, m_word);
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) check("word_xfer", out_word, exp_q.pop_front());
      else check("spurious_xfer", out_valid, 1'b0);
    end
    ready = !m_valid || out_ready;
    take  = in_valid && ready && !resync;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (resync) begin
      m_state = 0;
      m_cnt   = 0;
      m_bits  = '0;
    end else begin
      if (take) begin
        d = in_bit ^ m_inv[m_state][0];
        m_state = d ? m_nxt1[m_state] : m_nxt0[m_state];
        m_bits[m_cnt] = d;
        m_cnt++;
      end
      emit = (m_cnt == WIDTH);
`ifdef MEALY_DEC_FLUSH_EN
      if (flush && ready && m_cnt > 0) emit = 1'b1;
`endif
      if (emit) begin
        m_word  = m_bits;
        m_valid = 1'b1;
        exp_q.push_back(m_bits);
        m_bits  = '0;
        m_cnt   = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic clear_inputs();
    in_valid = 1'b0;
    in_bit   = 1'b0;
    resync   = 1'b0;
`ifdef MEALY_DEC_FLUSH_EN
    flush    = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic c);
    clear_inputs();
    in_valid = 1'b1;
    in_bit   = c;
    tick();
  endtask

  task automatic idle();
    clear_inputs();
    tick();
  endtask

  task automatic send_codes(input logic [7:0] codes, input int n);
    for (int i = 0; i < n; i++) send(codes[i]);
  endtask

  initial begin
    out_ready = 1'b0;
    do_reset();

    // reset state
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_word", out_word, '0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_state", dbg_state, 2'd0);

    // codes 1,0,0,1,0,1,0,1 -> A5, tracker S1
    out_ready = 1'b1;
    send_codes(8'b1010_1001, 8);
    check("t1_word", out_word, 8'hA5);
    check("t1_valid", out_valid, 1'b1);
    check("t1_state", dbg_state, 2'd1);
    idle();
    check("t1_valid_1cyc", out_valid, 1'b0);

    // codes 1,0,1,1,0,0,0,0 from S1 -> 09
    send_codes(8'b0000_1101, 8);
    check("t2_word", out_word, 8'h09);
    check("t2_state", dbg_state, 2'd0);
    idle();

    // backpressure: word held, bits refused
    out_ready = 1'b0;
    send_codes(8'b1010_1001, 8);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_word", out_word, 8'hA5);
      check("t3_ready_low", in_ready, 1'b0);
      send(1'($urandom_range(0, 1)));
    end
    out_ready = 1'b1;
    idle();
    check("t3_released", out_valid, 1'b0);
    send_codes(8'b0000_1101, 8);
    check("t3_next_word", out_word, 8'h09);
    idle();

    // resync after 3 bits, same-cycle bit dropped
    for (int i = 0; i < 3; i++) send(1'($urandom_range(0, 1)));
    clear_inputs();
    in_valid = 1'b1;
    in_bit   = 1'b1;
    resync   = 1'b1;
    tick();
    check("t4_state", dbg_state, 2'd0);
    send_codes(8'h00, 8);
    check("t4_word", out_word, 8'h00);
    check("t4_valid", out_valid, 1'b1);
    idle();

    // reset mid-word
    send_codes(8'b1010_1001, 5);
    do_reset();
    #1;
    check("t5_valid", out_valid, 1'b0);
    check("t5_word", out_word, '0);
    check("t5_state", dbg_state, 2'd0);
    send_codes(8'b1010_1001, 8);
    check("t5_word_after", out_word, 8'hA5);
    idle();

`ifdef MEALY_DEC_FLUSH_EN
    // flush partial word: codes 1,0,0 decode to bits 1,0,1, tracker in S2
    do_reset();
    out_ready = 1'b1;
    send_codes(8'b0000_0001, 3);
    clear_inputs();
    flush = 1'b1;
    tick();
    check("t6_word", out_word, 8'h05);
    check("t6_valid", out_valid, 1'b1);
    check("t6_state", dbg_state, 2'd2);
    clear_inputs();
    flush = 1'b1;
    tick();
    check("t6_noop_flush", out_valid, 1'b0);
`endif

    // random traffic
    for (int i = 0; i < 800; i++) begin
      clear_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      resync    = ($urandom_range(0, 31) == 0);
`ifdef MEALY_DEC_FLUSH_EN
      flush     = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end

    // drain
    out_ready = 1'b1;
    idle();
    idle();
    check("drain_empty", WIDTH'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
